// File: rtl/clkdiv_scheduler.sv
// ----------------------------------------------------------------------------
// clkdiv_scheduler
//   Run controller for the digital clock's prescaled divider. It drives the
//   divider enable and prescaler and turns the divider output into one-cycle
//   o_tick pulses. Prescaler changes requested while the divider is running
//   wait for the next divider rising edge (or a timeout). The divider is then
//   reloaded, so no divided period is cut short mid-count.
//
// Ports
//   i_clk            system clock, rising edge
//   i_reset          asynchronous, active-high reset
//   i_run            level: 1 = divider running, 0 = stopped
//   i_req            prescaler change request, held high until o_ack
//   i_req_presc      requested prescaler, stable while i_req is high
//   o_ack            1-cycle pulse: request completed (applied or rejected)
//   o_err            1-cycle pulse with o_ack when the request was rejected
//   o_div_enable     to divider enable
//   o_div_prescaler  to divider prescaler
//   i_div_clk        divider output feedback (same clock domain)
//   o_tick           1-cycle pulse per divider rising edge
//   o_busy           high while a change is draining or reloading
// ----------------------------------------------------------------------------
module clkdiv_scheduler #(
    parameter int PRESC_W       = 4,
    parameter int DEFAULT_PRESC = 10,
    parameter int MIN_PRESC     = 2,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_run,
    input  logic               i_req,
    input  logic [PRESC_W-1:0] i_req_presc,
    output logic               o_ack,
    output logic               o_err,
    output logic               o_div_enable,
    output logic [PRESC_W-1:0] o_div_prescaler,
    input  logic               i_div_clk,
    output logic               o_tick,
    output logic               o_busy
);

    localparam int CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [PRESC_W-1:0] DEF_P     = PRESC_W'(DEFAULT_PRESC);
    localparam logic [PRESC_W-1:0] MIN_P     = PRESC_W'(MIN_PRESC);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RELOAD = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 div_q;
    logic                 tick_q;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 armed_q, armed_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [PRESC_W-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 rise_s;
    logic                 take_s;
    logic                 good_s;
    logic                 rej_s;

    // Rising-edge detect of the divider output; also used to end DRAIN.
    assign rise_s = i_div_clk & ~div_q;

    // A request is only taken once per assertion of i_req and never while a
    // previous change is still in flight (busy_q mirrors DRAIN/RELOAD).
    assign take_s = i_req & armed_q & ~busy_q;
    assign rej_s  = take_s & (i_req_presc < MIN_P);
    assign good_s = take_s & ~(i_req_presc < MIN_P);

    // Next-state, next-output and request bookkeeping.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        pending_d = pending_q;
        cnt_d     = CNT_ZERO;
        ack_d     = rej_s;
        err_d     = rej_s;

        if (!i_req) begin
            armed_d = 1'b1;
        end else if (take_s) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end

        if (good_s) begin
            pending_d = i_req_presc;
        end else begin
            pending_d = pending_q;
        end

        case (state_q)
            ST_IDLE: begin
                // A request in the same cycle as i_run wins; run is taken
                // on the following cycle.
                if (good_s) begin
                    presc_d = i_req_presc;
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (rej_s) begin
                    state_d = ST_IDLE;
                end else if (i_run) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Stopping while a legal request arrives: nothing is running,
                // so the new prescaler can be applied straight away.
                if (!i_run) begin
                    state_d = ST_IDLE;
                    if (good_s) begin
                        presc_d = i_req_presc;
                        ack_d   = 1'b1;
                    end else begin
                        presc_d = presc_q;
                    end
                end else if (good_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q + CNT_ONE;
                if (!i_run) begin
                    presc_d = pending_q;
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (rise_s || (cnt_q == CNT_LAST)) begin
                    state_d = ST_RELOAD;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RELOAD: begin
                // Enable is low for this single cycle, which clears the
                // divider before it restarts with the new prescaler.
                presc_d = pending_q;
                ack_d   = 1'b1;
                if (i_run) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered decodes of the next state so outputs track the state.
        en_d   = (state_d == ST_RUN)   || (state_d == ST_DRAIN);
        busy_d = (state_d == ST_DRAIN) || (state_d == ST_RELOAD);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            div_q     <= 1'b0;
            tick_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            armed_q   <= 1'b1;
            presc_q   <= DEF_P;
            pending_q <= DEF_P;
            cnt_q     <= CNT_ZERO;
        end else begin
            state_q   <= state_d;
            div_q     <= i_div_clk;
            tick_q    <= rise_s;
            ack_q     <= ack_d;
            err_q     <= err_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            armed_q   <= armed_d;
            presc_q   <= presc_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_ack           = ack_q;
    assign o_err           = err_q;
    assign o_div_enable    = en_q;
    assign o_div_prescaler = presc_q;
    assign o_tick          = tick_q;
    assign o_busy          = busy_q;

endmodule

// File: tb/tb_clkdiv_scheduler.sv
// ----------------------------------------------------------------------------
// tb_clkdiv_scheduler
//   Bench for clkdiv_scheduler. A behavioural divider model closes the loop on
//   i_div_clk. Requests push their expected completion (error flag, resulting
//   prescaler, latency) into a scoreboard queue; a monitor process pops it on
//   every o_ack and also checks o_tick against the sampled divider output.
// ----------------------------------------------------------------------------
module tb_clkdiv_scheduler;

    localparam int TO = 64;

    typedef struct {
        logic       err;
        logic [3:0] presc;
        int         t0;
        int         exact;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       req;
    logic [3:0] req_presc;
    logic       o_ack, o_err, o_div_enable, o_tick, o_busy;
    logic [3:0] o_div_prescaler;
    logic       div_clk;
    logic       div_out = 1'b0;
    logic [3:0] dcnt = 4'd0;
    logic       hold_low;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         ack_cnt = 0;
    int         ack_base = 0;
    int         last_ack_cyc = 0;
    int         run_since = 0;
    logic [3:0] cur_presc;
    exp_t       sb[$];
    int         tick_t[$];

    // monitor-private state
    exp_t       mon_e;
    int         mon_lat;
    int         skip = 0;
    logic       v1 = 1'b0;
    logic       v2 = 1'b0;

    clkdiv_scheduler dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_run           (run),
        .i_req           (req),
        .i_req_presc     (req_presc),
        .o_ack           (o_ack),
        .o_err           (o_err),
        .o_div_enable    (o_div_enable),
        .o_div_prescaler (o_div_prescaler),
        .i_div_clk       (div_clk),
        .o_tick          (o_tick),
        .o_busy          (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: toggles every P enabled cycles (period 2P); disable clears it.
    always @(posedge clk) begin
        if (o_div_enable !== 1'b1) begin
            dcnt    <= 4'd0;
            div_out <= 1'b0;
        end else if (dcnt >= o_div_prescaler - 4'd1) begin
            dcnt    <= 4'd0;
            div_out <= ~div_out;
        end else begin
            dcnt <= dcnt + 4'd1;
        end
    end

    assign div_clk = div_out & ~hold_low;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no event expected one within budget (cycle %0d)", nm, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ticks(input int n);
        int target;
        int k;
        target = tick_t.size() + n;
        k = 0;
        while (tick_t.size() < target && k < 600) begin
            step(1);
            k++;
        end
        if (tick_t.size() < target) fail_timeout("tick_wait");
    endtask

    task automatic start_req(input logic [3:0] p, input int exact);
        exp_t e;
        e.err   = (p < 4'd2);
        e.presc = e.err ? cur_presc : p;
        e.t0    = cyc;
        e.exact = exact;
        sb.push_back(e);
        if (!e.err) cur_presc = p;
        ack_base  = ack_cnt;
        req_presc = p;
        req       = 1'b1;
    endtask

    task automatic finish_req(input bit may_drop);
        int k;
        k = 0;
        while (ack_cnt == ack_base && k < 100) begin
            step(1);
            k++;
            if (may_drop && run && $urandom_range(0, 29) == 0) begin
                run       = 1'b0;
                run_since = cyc;
            end
        end
        if (ack_cnt == ack_base) begin
            fail_timeout("ack_wait");
            sb.delete();
        end
        req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_enable"}, o_div_enable, 0);
        check({tag, "_presc"}, o_div_prescaler, 10);
        check({tag, "_ack"}, o_ack, 0);
        check({tag, "_err"}, o_err, 0);
        check({tag, "_tick"}, o_tick, 0);
        check({tag, "_busy"}, o_busy, 0);
    endtask

    initial begin
        int nb;
        int n;
        int base;
        logic [3:0] p;
        int exact;

        rst       = 1'b1;
        run       = 1'b0;
        req       = 1'b0;
        req_presc = 4'd0;
        hold_low  = 1'b0;
        cur_presc = 4'd10;

        // Monitor: scoreboard pop on o_ack, per-cycle tick check.
        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    skip = 2;
                end else begin
                    if (o_ack) begin
                        ack_cnt++;
                        last_ack_cyc = cyc;
                        if (sb.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_ack: got ack expected none (cycle %0d)", cyc);
                        end else begin
                            mon_e   = sb.pop_front();
                            mon_lat = cyc - mon_e.t0;
                            check("ack_err", o_err, mon_e.err);
                            check("ack_presc", o_div_prescaler, mon_e.presc);
                            if (mon_e.exact > 0)
                                check("ack_latency", mon_lat, mon_e.exact);
                            else
                                check("ack_latency_bound", (mon_lat >= 1 && mon_lat <= TO + 2), 1);
                        end
                    end else begin
                        check("err_without_ack", o_err, 0);
                    end
                    if (skip > 0) skip--;
                    else check("tick", o_tick, v1 & ~v2);
                    if (o_tick) tick_t.push_back(cyc);
                end
                v2 = v1;
                v1 = div_clk;
            end
        join_none

        // Test 1: reset values, enable after one cycle, 20-cycle tick period.
        step(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        step(1);
        run = 1'b1;
        run_since = cyc;
        @(negedge clk);
        check("enable_before_run", o_div_enable, 0);
        step(1);
        check("enable_after_run", o_div_enable, 1);
        wait_ticks(3);
        n = tick_t.size();
        if (n >= 3) begin
            check("period_10_a", tick_t[n-1] - tick_t[n-2], 20);
            check("period_10_b", tick_t[n-2] - tick_t[n-3], 20);
        end

        // Test 3: illegal request in RUN is rejected next cycle, no change.
        step(5);
        start_req(4'd1, 1);
        finish_req(1'b0);
        check("reject_busy", o_busy, 0);
        check("reject_still_running", o_div_enable, 1);
        check("reject_presc_kept", o_div_prescaler, 10);

        // Test 2: mid-period change to 4 waits for the next edge, then 8-cycle ticks.
        wait_ticks(1);
        step(5);
        nb = tick_t.size();
        start_req(4'd4, 0);
        step(2);
        check("drain_busy", o_busy, 1);
        finish_req(1'b0);
        if (tick_t.size() > nb && nb >= 1) begin
            check("ack_after_edge", last_ack_cyc - tick_t[nb], 1);
            check("period_before_change", tick_t[nb] - tick_t[nb-1], 20);
        end else begin
            fail_timeout("drain_edge_tick");
        end
        wait_ticks(4);
        n = tick_t.size();
        check("period_4_a", tick_t[n-1] - tick_t[n-2], 8);
        check("period_4_b", tick_t[n-2] - tick_t[n-3], 8);

        // Test 4: no divider edge during DRAIN -> timeout reload.
        hold_low = 1'b1;
        step(3);
        start_req(4'd7, TO + 2);
        finish_req(1'b0);
        hold_low = 1'b0;
        step(1);
        check("timeout_running", o_div_enable, 1);

        // Test 5: IDLE request together with run; not re-accepted while held.
        run = 1'b0;
        run_since = cyc;
        step(3);
        start_req(4'd6, 1);
        run = 1'b1;
        run_since = cyc;
        @(posedge clk);
        @(negedge clk);
        check("idle_req_ack", o_ack, 1);
        check("idle_req_enable_low", o_div_enable, 0);
        check("idle_req_presc", o_div_prescaler, 6);
        @(negedge clk);
        check("idle_then_run", o_div_enable, 1);
        base = ack_cnt;
        step(5);
        req = 1'b0;
        step(2);
        check("held_req_single_ack", ack_cnt - base, 0);

        // Test 6: asynchronous reset during DRAIN drops the request.
        hold_low = 1'b1;
        step(2);
        start_req(4'd9, 0);
        step(3);
        check("pre_reset_busy", o_busy, 1);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        sb.delete();
        cur_presc = 4'd10;
        req = 1'b0;
        hold_low = 1'b0;
        base = ack_cnt;
        step(2);
        rst = 1'b0;
        step(10);
        check("no_ack_after_reset", ack_cnt - base, 0);
        check("presc_after_reset", o_div_prescaler, 10);

        // Random phase: random run level, timing and prescaler values.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                run = ~run;
                run_since = cyc;
            end
            step($urandom_range(0, 25));
            p = 4'($urandom_range(0, 15));
            if (p < 4'd2) exact = 1;
            else if (!run && (cyc - run_since >= 2)) exact = 1;
            else exact = 0;
            start_req(p, exact);
            finish_req(1'b1);
            step(1);
        end
        step(10);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
